turfc_wb_bridge: RTL

- Byte-stream to WISHBONE master bridge that drives the turfc master port of the control-bus interconnect.
- Accepts command packets from the TURF serial link deserializer as bytes, then runs one WISHBONE classic cycle.
- Returns a status/read-data response as bytes to the link serializer.
- Exactly one transaction in flight; no pipelining on the bus side.

---
 rtl/turfc_wb_bridge_pkg.sv | 29 ++
 rtl/turfc_wb_bridge.sv | 130 +++++++++++++
 2 files changed

// File: rtl/turfc_wb_bridge_pkg.sv
// Shared definitions for the TURF byte-stream to WISHBONE bridge:
// field widths, header/status bit positions and state encoding.
package turfc_wb_bridge_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADR_W  = 20;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned TMO_W  = 16;

  localparam int unsigned HDR_WE      = 7;
  localparam int unsigned HDR_SEL_MSB = 3;
  localparam int unsigned HDR_SEL_LSB = 0;

  localparam int unsigned ST_ACK = 7;
  localparam int unsigned ST_ERR = 6;
  localparam int unsigned ST_RTY = 5;
  localparam int unsigned ST_TMO = 4;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_ADR  = 3'd1,
    S_WDAT = 3'd2,
    S_BUS  = 3'd3,
    S_STAT = 3'd4,
    S_RDAT = 3'd5
  } state_t;

endpackage

// File: rtl/turfc_wb_bridge.sv
// Byte-stream command packets in, one WISHBONE classic cycle out, status and
// read data returned as bytes. One transaction in flight at a time.
module turfc_wb_bridge
  import turfc_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BYTE_W-1:0] rx_dat_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [BYTE_W-1:0] tx_dat_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic [DAT_W-1:0]  dat_o,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [DAT_W-1:0]  dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic              rty_i
);

  state_t             state, state_nxt;
  logic [1:0]         bcnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [DAT_W-1:0]   rdata;
  logic [BYTE_W-1:0]  status;
  logic               rx_fire, tx_fire, term, tmo_hit, byte_step;
  logic               rx_ready_nxt, tx_valid_nxt, cyc_nxt;

  assign rx_fire   = rx_valid_i & rx_ready_o;
  assign tx_fire   = tx_valid_o & tx_ready_i;
  assign term      = ack_i | err_i | rty_i;
  // Last permitted stb cycle: the counter starts at zero on the first one.
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign byte_step = (rx_fire & ((state == S_ADR) | (state == S_WDAT))) |
                     (tx_fire & (state == S_RDAT));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR:  if (rx_fire) state_nxt = S_ADR;
      S_ADR:  if (rx_fire && bcnt == 2'd2) state_nxt = we_o ? S_WDAT : S_BUS;
      S_WDAT: if (rx_fire && bcnt == 2'd3) state_nxt = S_BUS;
      S_BUS:  if (term || tmo_hit) state_nxt = S_STAT;
      S_STAT: if (tx_fire) state_nxt = we_o ? S_HDR : S_RDAT;
      S_RDAT: if (tx_fire && bcnt == 2'd3) state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  // Control outputs are registered copies decoded from the upcoming state.
  always_comb begin
    rx_ready_nxt = 1'b0;
    tx_valid_nxt = 1'b0;
    cyc_nxt      = 1'b0;
    case (state_nxt)
      S_HDR, S_ADR, S_WDAT: rx_ready_nxt = 1'b1;
      S_BUS:                cyc_nxt      = 1'b1;
      S_STAT, S_RDAT:       tx_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // A termination on the final allowed cycle takes precedence over timeout.
  always_comb begin
    status         = '0;
    status[ST_ACK] = ack_i;
    status[ST_ERR] = err_i;
    status[ST_RTY] = rty_i;
    status[ST_TMO] = ~term;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_ready_o <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_dat_o   <= '0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      sel_o      <= '0;
      bcnt       <= '0;
      tmo_cnt    <= '0;
      rdata      <= '0;
    end else begin
      rx_ready_o <= rx_ready_nxt;
      tx_valid_o <= tx_valid_nxt;
      cyc_o      <= cyc_nxt;
      stb_o      <= cyc_nxt;

      if (state != state_nxt) bcnt <= '0;
      else if (byte_step)     bcnt <= 2'(bcnt + 2'd1);

      if (state == S_BUS) tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
      else                tmo_cnt <= '0;

      case (state)
        S_HDR: if (rx_fire) begin
          we_o  <= rx_dat_i[HDR_WE];
          sel_o <= rx_dat_i[HDR_SEL_MSB:HDR_SEL_LSB];
        end
        S_ADR:  if (rx_fire) adr_o <= {adr_o[ADR_W-BYTE_W-1:0], rx_dat_i};
        S_WDAT: if (rx_fire) dat_o <= {dat_o[DAT_W-BYTE_W-1:0], rx_dat_i};
        S_BUS: if (term || tmo_hit) begin
          tx_dat_o <= status;
          rdata    <= ack_i ? dat_i : '0;
        end
        S_STAT, S_RDAT: if (tx_fire && !we_o) begin
          tx_dat_o <= rdata[DAT_W-1 -: BYTE_W];
          rdata    <= {rdata[DAT_W-BYTE_W-1:0], BYTE_W'(0)};
        end
        default: ;
      endcase
    end
  end

endmodule
